// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory bus between the icache read port and the dcache
// read and write ports. One transaction is in flight at a time, sequenced as
// address phase -> data phase (-> write response). The icache and dcache
// sides are served round-robin; inside the dcache side a pending write always
// beats a pending read.
//
// Parameters:
//   LINE_WORDS     beats per cache-line burst (2..256)
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   ic_rd_*        icache read request / grant / data-valid
//   dc_rd_*        dcache read request / grant / data-valid
//   rd_data/last   read beat data and final-beat flag, shared by both readers
//   dc_wr_*        dcache write request / grant / beat handshake / done pulse
//   bus_*          external bus: address phase, read data, write data, write
//                  response
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_rd_addr,
  input  logic        ic_rd_line,
  output logic        ic_rd_gnt,
  output logic        ic_rd_valid,
  input  logic        dc_rd_req,
  input  logic [31:0] dc_rd_addr,
  input  logic        dc_rd_line,
  output logic        dc_rd_gnt,
  output logic        dc_rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_wr_addr,
  input  logic        dc_wr_line,
  input  logic [3:0]  dc_wr_strb,
  input  logic [31:0] dc_wr_data,
  output logic        dc_wr_gnt,
  output logic        dc_wr_data_ready,
  output logic        dc_wr_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_len,
  output logic [3:0]  bus_strb,
  input  logic        bus_ack,
  input  logic        bus_rvalid,
  input  logic        bus_rlast,
  input  logic [31:0] bus_rdata,
  output logic        bus_wvalid,
  output logic        bus_wlast,
  output logic [31:0] bus_wdata,
  input  logic        bus_wready,
  input  logic        bus_bvalid
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_IC = 2'd0, OWN_DC_RD = 2'd1, OWN_DC_WR = 2'd2
  } owner_t;

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  state_t      state, state_n;
  owner_t      owner, win_owner;
  logic        last_side;   // side served last: 0 = icache, 1 = dcache
  logic [31:0] addr_r, win_addr;
  logic [7:0]  len_r, win_len, cnt;
  logic [3:0]  strb_r, win_strb;
  logic        d_pend, pick_d, win_valid;

  // Arbitration: only consulted in IDLE. On a tie between the two sides the
  // side that was not served last wins; last_side resets to icache so the
  // dcache side takes the first tie.
  always_comb begin
    d_pend    = dc_wr_req | dc_rd_req;
    pick_d    = d_pend & (~ic_rd_req | ~last_side);
    win_valid = d_pend | ic_rd_req;
    win_owner = OWN_IC;
    win_addr  = ic_rd_addr;
    win_len   = ic_rd_line ? LINE_LEN : 8'd0;
    win_strb  = 4'hf;
    if (pick_d) begin
      if (dc_wr_req) begin
        win_owner = OWN_DC_WR;
        win_addr  = dc_wr_addr;
        win_len   = dc_wr_line ? LINE_LEN : 8'd0;
        win_strb  = dc_wr_line ? 4'hf : dc_wr_strb;
      end else begin
        win_owner = OWN_DC_RD;
        win_addr  = dc_rd_addr;
        win_len   = dc_rd_line ? LINE_LEN : 8'd0;
        win_strb  = 4'hf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= OWN_IC;
      last_side <= 1'b0;
      addr_r    <= 32'd0;
      len_r     <= 8'd0;
      strb_r    <= 4'd0;
      cnt       <= 8'd0;
    end else begin
      if (state == IDLE && win_valid) begin
        owner     <= win_owner;
        last_side <= pick_d;
        addr_r    <= win_addr;
        len_r     <= win_len;
        strb_r    <= win_strb;
      end
      if ((state == RD_ADDR || state == WR_ADDR) && bus_ack)
        cnt <= 8'd0;
      else if (state == WR_DATA && bus_wready)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_valid)
                 state_n = (win_owner == OWN_DC_WR) ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (bus_ack) state_n = RD_DATA;
      RD_DATA: if (bus_rvalid && bus_rlast) state_n = IDLE;
      WR_ADDR: if (bus_ack) state_n = WR_DATA;
      WR_DATA: if (bus_wready && cnt == len_r) state_n = WR_RESP;
      WR_RESP: if (bus_bvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read data and write ready are pure pass-through so the bus sees zero
  // added latency; everything outside the owning state is held at 0.
  always_comb begin
    ic_rd_gnt        = 1'b0;
    dc_rd_gnt        = 1'b0;
    dc_wr_gnt        = 1'b0;
    ic_rd_valid      = 1'b0;
    dc_rd_valid      = 1'b0;
    rd_data          = 32'd0;
    rd_last          = 1'b0;
    dc_wr_data_ready = 1'b0;
    dc_wr_done       = 1'b0;
    bus_req          = 1'b0;
    bus_we           = 1'b0;
    bus_addr         = 32'd0;
    bus_len          = 8'd0;
    bus_strb         = 4'd0;
    bus_wvalid       = 1'b0;
    bus_wlast        = 1'b0;
    bus_wdata        = 32'd0;
    case (state)
      RD_ADDR, WR_ADDR: begin
        bus_req  = 1'b1;
        bus_we   = (state == WR_ADDR);
        bus_addr = addr_r;
        bus_len  = len_r;
        bus_strb = strb_r;
        ic_rd_gnt = bus_ack && owner == OWN_IC;
        dc_rd_gnt = bus_ack && owner == OWN_DC_RD;
        dc_wr_gnt = bus_ack && owner == OWN_DC_WR;
      end
      RD_DATA: begin
        ic_rd_valid = bus_rvalid && owner == OWN_IC;
        dc_rd_valid = bus_rvalid && owner == OWN_DC_RD;
        rd_data     = bus_rdata;
        rd_last     = bus_rlast;
      end
      WR_DATA: begin
        bus_wvalid       = 1'b1;
        bus_wdata        = dc_wr_data;
        bus_wlast        = (cnt == len_r);
        dc_wr_data_ready = bus_wready;
      end
      WR_RESP: dc_wr_done = bus_bvalid;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_rd_req, ic_rd_line, ic_rd_gnt, ic_rd_valid;
  logic [31:0] ic_rd_addr;
  logic        dc_rd_req, dc_rd_line, dc_rd_gnt, dc_rd_valid;
  logic [31:0] dc_rd_addr;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        dc_wr_req, dc_wr_line, dc_wr_gnt, dc_wr_data_ready, dc_wr_done;
  logic [31:0] dc_wr_addr, dc_wr_data;
  logic [3:0]  dc_wr_strb;
  logic        bus_req, bus_we, bus_ack, bus_rvalid, bus_rlast;
  logic        bus_wvalid, bus_wlast, bus_wready, bus_bvalid;
  logic [31:0] bus_addr, bus_rdata, bus_wdata;
  logic [7:0]  bus_len;
  logic [3:0]  bus_strb;

  mem_bus_arbiter #(.LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_line(ic_rd_line),
    .ic_rd_gnt(ic_rd_gnt), .ic_rd_valid(ic_rd_valid),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_line(dc_rd_line),
    .dc_rd_gnt(dc_rd_gnt), .dc_rd_valid(dc_rd_valid),
    .rd_data(rd_data), .rd_last(rd_last),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_line(dc_wr_line),
    .dc_wr_strb(dc_wr_strb), .dc_wr_data(dc_wr_data), .dc_wr_gnt(dc_wr_gnt),
    .dc_wr_data_ready(dc_wr_data_ready), .dc_wr_done(dc_wr_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len),
    .bus_strb(bus_strb), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid),
    .bus_rlast(bus_rlast), .bus_rdata(bus_rdata), .bus_wvalid(bus_wvalid),
    .bus_wlast(bus_wlast), .bus_wdata(bus_wdata), .bus_wready(bus_wready),
    .bus_bvalid(bus_bvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  kind;   // 1 grant, 2 read beat, 3 write beat, 4 write done
    logic [31:0] d0;
    logic [31:0] d1;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  function automatic ev_t mk_gnt(logic [2:0] g, logic we, logic [7:0] len,
                                 logic [3:0] s, logic [31:0] a);
    ev_t e;
    e.kind = 4'd1;
    e.d0   = {16'd0, g, we, len, s};
    e.d1   = a;
    return e;
  endfunction

  function automatic ev_t mk_rd(logic [1:0] who, logic last, logic [31:0] d);
    ev_t e;
    e.kind = 4'd2;
    e.d0   = {29'd0, who, last};
    e.d1   = d;
    return e;
  endfunction

  function automatic ev_t mk_wr(logic last, logic rdy, logic [31:0] d);
    ev_t e;
    e.kind = 4'd3;
    e.d0   = {30'd0, last, rdy};
    e.d1   = d;
    return e;
  endfunction

  function automatic ev_t mk_done();
    ev_t e;
    e.kind = 4'd4;
    e.d0   = 32'd1;
    e.d1   = 32'd0;
    return e;
  endfunction

  function automatic logic [63:0] outs_all();
    return {8'd0, ic_rd_gnt, dc_rd_gnt, ic_rd_valid, dc_rd_valid, rd_last,
            dc_wr_gnt, dc_wr_data_ready, dc_wr_done, bus_req, bus_we,
            bus_wvalid, bus_wlast, bus_len, bus_strb,
            rd_data | bus_addr | bus_wdata};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_ev(string name, ev_t obs);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected: got kind=%0d d0=%h d1=%h, expected none",
               name, obs.kind, obs.d0, obs.d1);
    end else begin
      e = exp_q.pop_front();
      if (e != obs) begin
        fails++;
        $display("FAIL %s: got kind=%0d d0=%h d1=%h, expected kind=%0d d0=%h d1=%h",
                 name, obs.kind, obs.d0, obs.d1, e.kind, e.d0, e.d1);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ic_rd_gnt || dc_rd_gnt || dc_wr_gnt)
        check_ev("gnt", mk_gnt({dc_wr_gnt, dc_rd_gnt, ic_rd_gnt}, bus_we,
                               bus_len, bus_strb, bus_addr));
      if (ic_rd_valid || dc_rd_valid)
        check_ev("rd_beat", mk_rd({dc_rd_valid, ic_rd_valid}, rd_last, rd_data));
      if (bus_wvalid && bus_wready)
        check_ev("wr_beat", mk_wr(bus_wlast, dc_wr_data_ready, bus_wdata));
      if (dc_wr_done)
        check_ev("wr_done", mk_done());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read transaction from requester who (0 = icache, 1 = dcache).
  // abort_at > 0 asserts reset after that many beats instead of finishing.
  task automatic rd_xact(input bit who, input logic [31:0] addr, input bit line,
                         input int ack_dly, input bit gaps,
                         input logic [31:0] base, input int abort_at);
    int nb;
    nb = line ? 4 : 1;
    if (who) begin
      dc_rd_req = 1'b1; dc_rd_addr = addr; dc_rd_line = line;
    end else begin
      ic_rd_req = 1'b1; ic_rd_addr = addr; ic_rd_line = line;
    end
    exp_q.push_back(mk_gnt(who ? 3'b010 : 3'b001, 1'b0,
                           line ? 8'd3 : 8'd0, 4'hf, addr));
    tick();
    chk("rd_addr_phase", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, addr});
    bus_ack = 1'b0;
    repeat (ack_dly) tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    if (who) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        bus_rvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rlast = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        chk("reset_mid_read_outputs", outs_all(), 64'd0);
        tick();
        bus_rvalid = 1'b0; bus_rlast = 1'b0;
        return;
      end
      if (gaps) begin
        bus_rvalid = 1'b0;
        tick();
      end
      bus_rvalid = 1'b1;
      bus_rlast  = (i == nb - 1);
      bus_rdata  = base + 32'(i);
      exp_q.push_back(mk_rd(who ? 2'b10 : 2'b01, i == nb - 1, base + 32'(i)));
      tick();
    end
    bus_rvalid = 1'b0;
    bus_rlast  = 1'b0;
  endtask

  task automatic wr_xact(input logic [31:0] addr, input bit line,
                         input logic [3:0] strb, input logic [31:0] base,
                         input bit toggle, input int b_dly);
    int nb, b, c;
    bit wr;
    nb = line ? 4 : 1;
    dc_wr_req = 1'b1; dc_wr_addr = addr; dc_wr_line = line;
    dc_wr_strb = strb; dc_wr_data = base;
    exp_q.push_back(mk_gnt(3'b100, 1'b1, line ? 8'd3 : 8'd0,
                           line ? 4'hf : strb, addr));
    tick();
    chk("wr_addr_phase", {bus_req, bus_we, bus_addr}, {1'b1, 1'b1, addr});
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    dc_wr_req = 1'b0;
    b = 0;
    c = 0;
    while (b < nb && c < 40) begin
      wr = toggle ? (c % 2 == 0) : 1'b1;
      bus_wready = wr;
      dc_wr_data = base + 32'(b);
      if (wr) exp_q.push_back(mk_wr(b == nb - 1, 1'b1, base + 32'(b)));
      tick();
      if (wr) b++;
      c++;
    end
    bus_wready = 1'b0;
    repeat (b_dly) tick();
    bus_bvalid = 1'b1;
    exp_q.push_back(mk_done());
    tick();
    bus_bvalid = 1'b0;
  endtask

  logic [31:0] rr_data [4];
  int          n;

  initial begin
    rst_n = 1'b0;
    ic_rd_req = 0; ic_rd_addr = 0; ic_rd_line = 0;
    dc_rd_req = 0; dc_rd_addr = 0; dc_rd_line = 0;
    dc_wr_req = 0; dc_wr_addr = 0; dc_wr_line = 0; dc_wr_strb = 0; dc_wr_data = 0;
    bus_ack = 0; bus_rvalid = 0; bus_rlast = 0; bus_rdata = 0;
    bus_wready = 0; bus_bvalid = 0;
    repeat (3) tick();
    chk("reset_outputs", outs_all(), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Both read sides held continuously from reset: D, I, D, I.
    rr_data[0] = 32'hD000_0001; rr_data[1] = 32'h1000_0002;
    rr_data[2] = 32'hD000_0003; rr_data[3] = 32'h1000_0004;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h3000_0000; ic_rd_line = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h4000_0000; dc_rd_line = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk_gnt((k % 2 == 0) ? 3'b010 : 3'b001, 1'b0, 8'd0, 4'hf,
                             (k % 2 == 0) ? 32'h4000_0000 : 32'h3000_0000));
      exp_q.push_back(mk_rd((k % 2 == 0) ? 2'b10 : 2'b01, 1'b1, rr_data[k]));
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus_req && n < 10) begin
        tick();
        n++;
      end
      chk("rr_bus_req", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      bus_rvalid = 1'b1; bus_rlast = 1'b1; bus_rdata = rr_data[k];
      tick();
      bus_rvalid = 1'b0; bus_rlast = 1'b0;
      if (k == 3) begin
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
      end
    end
    tick();
    chk("rr_idle_after", {31'd0, bus_req}, 32'd0);

    // dcache line read, ack after 2 cycles, beats with gaps.
    rd_xact(1'b1, 32'h1000_0040, 1'b1, 2, 1'b1, 32'hC0DE_0000, 0);
    tick();

    // Single-word write with partial strobe.
    wr_xact(32'h1FE0_01E0, 1'b0, 4'b0010, 32'h0000_AB00, 1'b0, 1);
    tick();

    // Write and read pending together on the dcache side: write first.
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_0100; dc_rd_line = 1'b0;
    wr_xact(32'h0000_0200, 1'b0, 4'b0100, 32'h5555_0000, 1'b0, 0);
    rd_xact(1'b1, 32'h0000_0100, 1'b0, 0, 1'b0, 32'h7777_0000, 0);
    tick();

    // Line write with wready toggling; strobe input ignored for lines.
    wr_xact(32'h2000_0080, 1'b1, 4'b0001, 32'hA5A5_0010, 1'b1, 2);
    tick();

    // icache line read, reset after 2 beats, then a normal request.
    rd_xact(1'b0, 32'h5000_0100, 1'b1, 0, 1'b0, 32'h1111_0000, 2);
    rd_xact(1'b1, 32'h6000_0004, 1'b0, 1, 1'b0, 32'h2222_0000, 0);
    repeat (3) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
